// File: rtl/reg_file_2r1w_sb_pkg.sv
// Shared constants and helpers for the two-read / one-write register file
// with its busy scoreboard.
package reg_file_2r1w_sb_pkg;

   // Default geometry: sixteen 16-bit registers.
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 4;

   // Location that is hardwired to zero when the zero register is enabled.
   localparam int ZERO_LOC = 0;

   // Ceiling log2, used to size counters that must hold 0..N inclusive.
   function automatic int rf_clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/reg_file_2r1w_sb_scoreboard.sv
// Busy scoreboard: one bit per register plus a running count of set bits.
// Decode reserves a destination, write-back releases it. The enables arriving
// here are already filtered by the top level (the zero register never reaches
// the scoreboard), so every request seen here is acted upon.
module rf_scoreboard
   import reg_file_2r1w_sb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rsv,
   input  logic [ADDR_W-1:0] rsv_loc,
   input  logic              write,
   input  logic [ADDR_W-1:0] wrt_loc,
   input  logic [ADDR_W-1:0] look_loc1,
   input  logic [ADDR_W-1:0] look_loc2,
   output logic              look_busy1,
   output logic              look_busy2,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = rf_clog2(DEPTH + 1);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;
   logic [CNT_W-1:0] count;
   logic             rsv_new;
   logic             release_hit;

   // Next busy vector: release first, then reserve, so a reservation landing
   // on the location being written back leaves the bit set (the new producer
   // wins). The count only moves on real 0->1 and 1->0 transitions.
   always_comb begin
      busy_next   = busy;
      rsv_new     = 1'b0;
      release_hit = 1'b0;
      if (write) begin
         busy_next[wrt_loc] = 1'b0;
      end
      if (rsv) begin
         busy_next[rsv_loc] = 1'b1;
      end
      rsv_new     = rsv && !busy[rsv_loc];
      release_hit = write && busy[wrt_loc] && !(rsv && (rsv_loc == wrt_loc));
   end

   // Busy bits: cleared asynchronously, otherwise follow the computed vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // Busy count: +1 for a new reservation, -1 for a release, both cancel.
   // The range 0..DEPTH fits the counter, so no wrap protection is needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({rsv_new, release_hit})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Two independent combinational lookups of the registered busy bits.
   always_comb begin
      look_busy1 = busy[look_loc1];
      look_busy2 = busy[look_loc2];
   end

   assign busy_cnt = count;

endmodule

// File: rtl/reg_file_2r1w_sb.sv
// Register file with two combinational read ports, one synchronous write
// port, optional hardwired zero register, optional write-to-read bypass and
// a per-register busy scoreboard for issue stalls.
module reg_file_2r1w_sb
   import reg_file_2r1w_sb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_loc1,
   output logic [DATA_W-1:0] rd_data1,
   output logic              rd_busy1,
   input  logic [ADDR_W-1:0] rd_loc2,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy2,
   input  logic              write,
   input  logic [ADDR_W-1:0] wrt_loc,
   input  logic [DATA_W-1:0] wrt_data,
   input  logic              rsv,
   input  logic [ADDR_W-1:0] rsv_loc,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int                DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_LOC);
   localparam bit                HAS_ZERO  = (ZERO_REG != 0);
   localparam bit                HAS_BYP   = (BYPASS != 0);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              write_eff;
   logic              rsv_eff;
   logic              sb_busy1;
   logic              sb_busy2;

   // Requests aimed at the hardwired zero register are dropped here so that
   // neither storage nor the scoreboard ever sees them.
   always_comb begin
      write_eff = write;
      rsv_eff   = rsv;
      if (HAS_ZERO && (wrt_loc == ZERO_ADDR)) begin
         write_eff = 1'b0;
      end
      if (HAS_ZERO && (rsv_loc == ZERO_ADDR)) begin
         rsv_eff = 1'b0;
      end
   end

   // Register storage: cleared asynchronously, one write per rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (write_eff) begin
         mem[wrt_loc] <= wrt_data;
      end
   end

   rf_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .rsv        (rsv_eff),
      .rsv_loc    (rsv_loc),
      .write      (write_eff),
      .wrt_loc    (wrt_loc),
      .look_loc1  (rd_loc1),
      .look_loc2  (rd_loc2),
      .look_busy1 (sb_busy1),
      .look_busy2 (sb_busy2),
      .busy_cnt   (busy_cnt)
   );

   // Read port 1: stored value, overridden by same-cycle write data when the
   // bypass is enabled. A bypassed value is final unless a new reservation
   // hits the same register this cycle. Zero register and reset force 0.
   always_comb begin
      rd_data1 = mem[rd_loc1];
      rd_busy1 = sb_busy1;
      if (HAS_BYP && write_eff && (wrt_loc == rd_loc1)) begin
         rd_data1 = wrt_data;
         rd_busy1 = rsv_eff && (rsv_loc == rd_loc1);
      end
      if (HAS_ZERO && (rd_loc1 == ZERO_ADDR)) begin
         rd_data1 = '0;
         rd_busy1 = 1'b0;
      end
      if (rst) begin
         rd_data1 = '0;
         rd_busy1 = 1'b0;
      end
   end

   // Read port 2: identical to port 1, fully independent address.
   always_comb begin
      rd_data2 = mem[rd_loc2];
      rd_busy2 = sb_busy2;
      if (HAS_BYP && write_eff && (wrt_loc == rd_loc2)) begin
         rd_data2 = wrt_data;
         rd_busy2 = rsv_eff && (rsv_loc == rd_loc2);
      end
      if (HAS_ZERO && (rd_loc2 == ZERO_ADDR)) begin
         rd_data2 = '0;
         rd_busy2 = 1'b0;
      end
      if (rst) begin
         rd_data2 = '0;
         rd_busy2 = 1'b0;
      end
   end

endmodule
